ser_word_scheduler: RTL and testbench

SER_WORD_SCHEDULER -- requirements
Module: ser_word_scheduler

---
 rtl/ser_word_scheduler_pkg.sv | 36 +++
 rtl/ser_word_scheduler_lane_mux.sv | 44 ++++
 rtl/ser_word_scheduler.sv | 149 ++++++++++++++
 tb/tb_ser_word_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ser_word_scheduler_pkg.sv
// Shared definitions for the serializer word scheduler: state encoding,
// lane word-select codes, default lane words and lane count.
package ser_word_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_NORMAL = 2'd1,
    ST_TEST   = 2'd2,
    ST_CALIB  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_SYNC = 2'd0,
    SEL_IDLE = 2'd1,
    SEL_DATA = 2'd2,
    SEL_ATU  = 2'd3
  } word_sel_e;

  localparam int          N_LANES       = 4;
  localparam int unsigned DEF_N_SYNC    = 16;
  localparam logic [31:0] DEF_SYNC_WORD = 32'h5A5A_5A5A;
  localparam logic [31:0] DEF_IDLE_WORD = 32'hEAAA_AAAA;

  // Sync counter must hold N_SYNC and is never narrower than 5 bits.
  function automatic int unsigned sync_cnt_width(input int unsigned n_sync);
    int unsigned w;
    w = $clog2(n_sync + 32'd1);
    if (w < 32'd5) begin
      w = 32'd5;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/ser_word_scheduler_lane_mux.sv
// One serializer lane: 4:1 word select and the output register that holds
// the selected word from one load strobe to the next.
module ser_lane_mux
  import ser_word_scheduler_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter logic [31:0] IDLE_WORD = DEF_IDLE_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [1:0]  sel,
  input  logic [31:0] data_word,
  input  logic [31:0] atu_word,
  output logic [31:0] lane_word
);

  logic [31:0] word_s;
  logic [31:0] word_r;

  // Word select for this lane.
  always_comb begin
    word_s = SYNC_WORD;
    case (sel)
      SEL_SYNC: word_s = SYNC_WORD;
      SEL_IDLE: word_s = IDLE_WORD;
      SEL_DATA: word_s = data_word;
      SEL_ATU:  word_s = atu_word;
      default:  word_s = SYNC_WORD;
    endcase
  end

  // Output register, updated only on a serializer load.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_r <= SYNC_WORD;
    end else if (load) begin
      word_r <= word_s;
    end
  end

  assign lane_word = word_r;

endmodule

// File: rtl/ser_word_scheduler.sv
// Serializer word scheduler: sync/normal/test/calibration FSM advancing on
// serializer load strobes, driving four lane muxes with a common select.
module ser_word_scheduler
  import ser_word_scheduler_pkg::*;
#(
  parameter int unsigned N_SYNC    = DEF_N_SYNC,
  parameter logic [31:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter logic [31:0] IDLE_WORD = DEF_IDLE_WORD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TEST_ENABLE,
  input  logic        CALIBRATION_BUSY,
  input  logic        handshake,
  input  logic        data_valid,
  input  logic [31:0] DATA32_0,
  input  logic [31:0] DATA32_1,
  input  logic [31:0] DATA32_2,
  input  logic [31:0] DATA32_3,
  input  logic [31:0] DATA32_ATU_0,
  input  logic [31:0] DATA32_ATU_1,
  input  logic [31:0] DATA32_ATU_2,
  input  logic [31:0] DATA32_ATU_3,
  output logic        data_ack,
  output logic [31:0] SER_DATA_0,
  output logic [31:0] SER_DATA_1,
  output logic [31:0] SER_DATA_2,
  output logic [31:0] SER_DATA_3,
  output logic [1:0]  mode,
  output logic        sync_done,
  output logic [7:0]  underrun_cnt
);

  localparam int unsigned CW = sync_cnt_width(N_SYNC);
  localparam logic [CW-1:0] SYNC_TARGET = CW'(N_SYNC);

  state_e        state_r, state_s;
  word_sel_e     sel_s;
  logic [CW-1:0] sync_cnt_r, sync_cnt_s;
  logic          sync_done_r;
  logic [7:0]    underrun_r, underrun_s;
  logic          ack_s;

  logic [31:0] data_s [N_LANES];
  logic [31:0] atu_s  [N_LANES];
  logic [31:0] ser_s  [N_LANES];

  assign data_s[0] = DATA32_0;
  assign data_s[1] = DATA32_1;
  assign data_s[2] = DATA32_2;
  assign data_s[3] = DATA32_3;
  assign atu_s[0]  = DATA32_ATU_0;
  assign atu_s[1]  = DATA32_ATU_1;
  assign atu_s[2]  = DATA32_ATU_2;
  assign atu_s[3]  = DATA32_ATU_3;

  // Next state, lane select and counter updates; nothing moves without a load.
  always_comb begin
    state_s    = state_r;
    sync_cnt_s = sync_cnt_r;
    underrun_s = underrun_r;
    sel_s      = SEL_SYNC;
    ack_s      = 1'b0;
    if (handshake) begin
      if (CALIBRATION_BUSY) begin
        state_s = ST_CALIB;
      end else if (state_r == ST_CALIB) begin
        state_s    = ST_SYNC;
        sync_cnt_s = '0;
      end else if (sync_cnt_r < SYNC_TARGET) begin
        state_s = ST_SYNC;
      end else if (TEST_ENABLE) begin
        state_s = ST_TEST;
      end else begin
        state_s = ST_NORMAL;
      end

      // The word loaded in this cycle belongs to the state being entered.
      case (state_s)
        ST_SYNC: begin
          sel_s = SEL_SYNC;
          if (sync_cnt_s < SYNC_TARGET) begin
            sync_cnt_s = sync_cnt_s + CW'(1);
          end else begin
            sync_cnt_s = sync_cnt_s;
          end
        end
        ST_CALIB:  sel_s = SEL_IDLE;
        ST_TEST:   sel_s = SEL_ATU;
        ST_NORMAL: begin
          if (data_valid) begin
            sel_s = SEL_DATA;
            ack_s = 1'b1;
          end else begin
            sel_s = SEL_IDLE;
            if (underrun_r != 8'hFF) begin
              underrun_s = underrun_r + 8'd1;
            end else begin
              underrun_s = underrun_r;
            end
          end
        end
        default: sel_s = SEL_SYNC;
      endcase
    end else begin
      sel_s = SEL_SYNC;
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_SYNC;
      sync_cnt_r  <= '0;
      sync_done_r <= 1'b0;
      underrun_r  <= 8'd0;
    end else begin
      state_r     <= state_s;
      sync_cnt_r  <= sync_cnt_s;
      sync_done_r <= (sync_cnt_s == SYNC_TARGET);
      underrun_r  <= underrun_s;
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    ser_lane_mux #(
      .SYNC_WORD (SYNC_WORD),
      .IDLE_WORD (IDLE_WORD)
    ) u_lane (
      .clk       (CLK),
      .rst       (RST),
      .load      (handshake),
      .sel       (sel_s),
      .data_word (data_s[g]),
      .atu_word  (atu_s[g]),
      .lane_word (ser_s[g])
    );
  end

  assign SER_DATA_0   = ser_s[0];
  assign SER_DATA_1   = ser_s[1];
  assign SER_DATA_2   = ser_s[2];
  assign SER_DATA_3   = ser_s[3];
  assign mode         = state_r;
  assign sync_done    = sync_done_r;
  assign underrun_cnt = underrun_r;
  assign data_ack     = ack_s && !RST;

endmodule

// File: tb/tb_ser_word_scheduler.sv
// Scoreboard bench for ser_word_scheduler: directed loads push expected lane
// words and status; a monitor compares one cycle after every load.
module tb_ser_word_scheduler;

  logic        CLK = 1'b0;
  logic        RST, TEST_ENABLE, CALIBRATION_BUSY, handshake, data_valid;
  logic [31:0] DATA32_0, DATA32_1, DATA32_2, DATA32_3;
  logic [31:0] DATA32_ATU_0, DATA32_ATU_1, DATA32_ATU_2, DATA32_ATU_3;
  logic        data_ack;
  logic [31:0] SER_DATA_0, SER_DATA_1, SER_DATA_2, SER_DATA_3;
  logic [1:0]  mode;
  logic        sync_done;
  logic [7:0]  underrun_cnt;

  always #5 CLK = ~CLK;

  ser_word_scheduler dut (
    .CLK(CLK), .RST(RST), .TEST_ENABLE(TEST_ENABLE),
    .CALIBRATION_BUSY(CALIBRATION_BUSY), .handshake(handshake),
    .data_valid(data_valid),
    .DATA32_0(DATA32_0), .DATA32_1(DATA32_1), .DATA32_2(DATA32_2), .DATA32_3(DATA32_3),
    .DATA32_ATU_0(DATA32_ATU_0), .DATA32_ATU_1(DATA32_ATU_1),
    .DATA32_ATU_2(DATA32_ATU_2), .DATA32_ATU_3(DATA32_ATU_3),
    .data_ack(data_ack),
    .SER_DATA_0(SER_DATA_0), .SER_DATA_1(SER_DATA_1),
    .SER_DATA_2(SER_DATA_2), .SER_DATA_3(SER_DATA_3),
    .mode(mode), .sync_done(sync_done), .underrun_cnt(underrun_cnt)
  );

  typedef struct packed {
    logic [3:0][31:0] w;
    logic [1:0]       m;
    logic             ack;
    logic             sd;
    logic [7:0]       ur;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] SYNC_V = {4{32'h5A5A_5A5A}};
  localparam logic [127:0] IDLE_V = {4{32'hEAAA_AAAA}};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][31:0] dw(input int k);
    logic [3:0][31:0] v;
    for (int n = 0; n < 4; n++) v[n] = 32'hD000_0000 + 32'(k * 16 + n);
    return v;
  endfunction

  task automatic set_data(input int k);
    logic [3:0][31:0] v;
    v = dw(k);
    DATA32_0 = v[0]; DATA32_1 = v[1]; DATA32_2 = v[2]; DATA32_3 = v[3];
  endtask

  // Drive one load at the current negedge and record what must follow it.
  task automatic hs(input logic te, input logic cal, input logic dv,
                    input logic [127:0] w, input logic [1:0] m,
                    input logic a, input logic sd, input logic [7:0] ur);
    exp_t e;
    TEST_ENABLE = te; CALIBRATION_BUSY = cal; data_valid = dv; handshake = 1'b1;
    e.w = w; e.m = m; e.ack = a; e.sd = sd; e.ur = ur;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    handshake = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  logic hs_seen = 1'b0;
  logic ack_seen = 1'b0;

  // Capture load strobe and combinational ack as seen by the active edge.
  always @(posedge CLK) begin
    hs_seen  <= handshake && !RST;
    ack_seen <= data_ack;
  end

  // Monitor: compare registered outputs one cycle after each load.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (hs_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got load with empty queue, required none at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("lane0", SER_DATA_0, e.w[0]);
        chk("lane1", SER_DATA_1, e.w[1]);
        chk("lane2", SER_DATA_2, e.w[2]);
        chk("lane3", SER_DATA_3, e.w[3]);
        chk("mode", 32'(mode), 32'(e.m));
        chk("data_ack", 32'(ack_seen), 32'(e.ack));
        chk("sync_done", 32'(sync_done), 32'(e.sd));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(e.ur));
      end
    end
  end

  initial begin
    RST = 1'b1; TEST_ENABLE = 1'b0; CALIBRATION_BUSY = 1'b0;
    handshake = 1'b1; data_valid = 1'b1;
    set_data(0);
    DATA32_ATU_0 = 32'h1234_5678; DATA32_ATU_1 = 32'hA1A1_A1A1;
    DATA32_ATU_2 = 32'hA2A2_A2A2; DATA32_ATU_3 = 32'hA3A3_A3A3;
    repeat (2) @(negedge CLK);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_lane0", SER_DATA_0, 32'h5A5A_5A5A);
    chk("rst_lane3", SER_DATA_3, 32'h5A5A_5A5A);
    chk("rst_sync_done", 32'(sync_done), 32'd0);
    chk("rst_underrun", 32'(underrun_cnt), 32'd0);
    chk("rst_data_ack", 32'(data_ack), 32'd0);
    RST = 1'b0;
    idle(1);

    // 16 sync loads, then four normal loads
    for (int i = 0; i < 16; i++) hs(1'b0, 1'b0, 1'b1, SYNC_V, 2'd0, 1'b0, (i == 15), 8'd0);
    for (int i = 16; i < 20; i++) begin
      set_data(i);
      hs(1'b0, 1'b0, 1'b1, dw(i), 2'd1, 1'b1, 1'b1, 8'd0);
    end
    idle(1);
    set_data(99);
    idle(2);
    chk("hold_lane0", SER_DATA_0, 32'hD000_0000 + 32'(19 * 16));

    // test mode, then TEST_ENABLE dropped without a load
    hs(1'b1, 1'b0, 1'b1, {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'h1234_5678},
       2'd2, 1'b0, 1'b1, 8'd0);
    idle(1);
    TEST_ENABLE = 1'b0;
    idle(2);
    chk("test_mode_held", 32'(mode), 32'd2);

    // underruns, then saturation
    for (int i = 1; i <= 3; i++) hs(1'b0, 1'b0, 1'b0, IDLE_V, 2'd1, 1'b0, 1'b1, 8'(i));
    for (int k = 0; k < 300; k++)
      hs(1'b0, 1'b0, 1'b0, IDLE_V, 2'd1, 1'b0, 1'b1, (k + 4 > 255) ? 8'd255 : 8'(k + 4));
    idle(1);

    // back-to-back normal loads
    for (int j = 0; j < 3; j++) begin
      set_data(30 + j);
      hs(1'b0, 1'b0, 1'b1, dw(30 + j), 2'd1, 1'b1, 1'b1, 8'd255);
    end
    idle(1);

    // calibration, resync, normal
    for (int i = 0; i < 4; i++) hs(1'b0, 1'b1, 1'b1, IDLE_V, 2'd3, 1'b0, 1'b1, 8'd255);
    for (int i = 0; i < 16; i++) hs(1'b0, 1'b0, 1'b1, SYNC_V, 2'd0, 1'b0, (i == 15), 8'd255);
    set_data(50);
    hs(1'b0, 1'b0, 1'b1, dw(50), 2'd1, 1'b1, 1'b1, 8'd255);
    idle(1);

    // reset coinciding with a load in NORMAL
    RST = 1'b1; handshake = 1'b1; data_valid = 1'b1; set_data(60);
    #1;
    chk("rst_hs_data_ack", 32'(data_ack), 32'd0);
    @(negedge CLK);
    chk("rst_hs_mode", 32'(mode), 32'd0);
    chk("rst_hs_lane0", SER_DATA_0, 32'h5A5A_5A5A);
    chk("rst_hs_lane2", SER_DATA_2, 32'h5A5A_5A5A);
    chk("rst_hs_sync_done", 32'(sync_done), 32'd0);
    chk("rst_hs_underrun", 32'(underrun_cnt), 32'd0);
    RST = 1'b0;
    hs(1'b0, 1'b0, 1'b1, SYNC_V, 2'd0, 1'b0, 1'b0, 8'd0);
    idle(3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
